bus_arbiter: RTL and testbench



---
 rtl/bus_arbiter_if.sv | 25 ++
 rtl/bus_arbiter.sv | 96 +++++++++
 tb/tb_bus_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Bus bundle between the arbiter and its sources/consumers.
// The arbiter takes the slave view; sources and the bus consumer take the master view.
interface bus_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int COUNT = 8
);
  logic [WIDTH*COUNT-1:0] in;
  logic [COUNT-1:0]       req;
  logic                   hold;
  logic [WIDTH-1:0]       out;
  logic [COUNT-1:0]       grant;
  logic                   valid;
  logic                   conflict;
  logic [15:0]            conflict_count;

  modport master (
    output in, req, hold,
    input  out, grant, valid, conflict, conflict_count
  );

  modport slave (
    input  in, req, hold,
    output out, grant, valid, conflict, conflict_count
  );
endinterface

// File: rtl/bus_arbiter.sv
// Registered bus arbiter: fixed-priority or round-robin selection with optional grant lock,
// one-hot grant, registered bus value and a saturating contention counter.
module bus_arbiter #(
  parameter int              WIDTH      = 8,
  parameter int              COUNT      = 8,
  parameter int              MODE       = 0,
  parameter logic [WIDTH-1:0] IDLE_VALUE = {WIDTH{1'b1}}
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.slave  bus
);

  localparam int IDX_W = (COUNT > 1) ? $clog2(COUNT) : 1;

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] win_idx;
  logic             win_valid;
  logic             lock;
  logic             found;
  logic [5:0]       req_count;
  logic             conflict_next;
  logic [COUNT-1:0] grant_next;
  logic [WIDTH-1:0] out_next;

  // Winner selection. A grant-lock is honoured only while the locked source keeps requesting.
  // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cur_idx   = '0;
    win_idx   = '0;
    win_valid = 1'b0;
    found     = 1'b0;
    req_count = '0;

    for (int j = 0; j < COUNT; j++) begin
      if (bus.grant[j]) cur_idx = IDX_W'(j);
      req_count = req_count + 6'(bus.req[j]);
    end

    lock = bus.hold && (|bus.grant) && bus.req[cur_idx];

    if (lock) begin
      win_valid = 1'b1;
      win_idx   = cur_idx;
    end else if (|bus.req) begin
      win_valid = 1'b1;
      if (MODE == 0) begin
        // Ascending scan: the last set bit seen is the highest index.
        for (int j = 0; j < COUNT; j++) begin
          if (bus.req[j]) win_idx = IDX_W'(j);
        end
      end else begin
        for (int k = 1; k <= COUNT; k++) begin
          int idx;
          idx = (int'(ptr) + k) % COUNT;
          if (!found && bus.req[idx]) begin
            found   = 1'b1;
            win_idx = IDX_W'(idx);
          end
        end
      end
    end

    conflict_next = (req_count > 6'd1);

    grant_next = '0;
    out_next   = IDLE_VALUE;
    if (win_valid) begin
      grant_next[win_idx] = 1'b1;
      out_next            = bus.in[int'(win_idx)*WIDTH +: WIDTH];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out            <= IDLE_VALUE;
      bus.grant          <= '0;
      bus.valid          <= 1'b0;
      bus.conflict       <= 1'b0;
      bus.conflict_count <= '0;
      ptr                <= IDX_W'(COUNT - 1);
    end else begin
      bus.out      <= out_next;
      bus.grant    <= grant_next;
      bus.valid    <= win_valid;
      bus.conflict <= conflict_next;
      if (conflict_next && (bus.conflict_count != 16'hFFFF)) begin
        bus.conflict_count <= bus.conflict_count + 16'd1;
      end
      if (win_valid) ptr <= win_idx;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: one fixed-priority and one round-robin instance (WIDTH=8, COUNT=4)
// driven from the same clock and reset.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  bus_arbiter_if #(.WIDTH(8), .COUNT(4)) if_fp ();
  bus_arbiter_if #(.WIDTH(8), .COUNT(4)) if_rr ();

  bus_arbiter #(.WIDTH(8), .COUNT(4), .MODE(0)) u_fp (.clk(clk), .reset(reset), .bus(if_fp));
  bus_arbiter #(.WIDTH(8), .COUNT(4), .MODE(1)) u_rr (.clk(clk), .reset(reset), .bus(if_rr));

  // Inputs change #1 after a rising edge; outputs are sampled at the same point after the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] in_v, input logic [3:0] req_v, input logic hold_v);
    if_fp.in = in_v; if_fp.req = req_v; if_fp.hold = hold_v;
    if_rr.in = in_v; if_rr.req = req_v; if_rr.hold = hold_v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(32'h44332211, 4'b0000, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(32'h44332211, 4'b1111, 1'b0);
    for (int c = 0; c < 2; c++) begin
      tick();
      tests_run++;
      if ({if_fp.out, if_fp.grant, if_fp.valid, if_fp.conflict, if_fp.conflict_count} !== {8'hFF, 4'b0000, 1'b0, 1'b0, 16'h0000}) begin
        tests_failed++;
        $display("FAIL reset_fp cycle %0d: got out=%h grant=%b valid=%b conflict=%b cc=%h, want out=ff grant=0000 valid=0 conflict=0 cc=0000",
                 c, if_fp.out, if_fp.grant, if_fp.valid, if_fp.conflict, if_fp.conflict_count);
      end
      tests_run++;
      if ({if_rr.out, if_rr.grant, if_rr.valid, if_rr.conflict_count} !== {8'hFF, 4'b0000, 1'b0, 16'h0000}) begin
        tests_failed++;
        $display("FAIL reset_rr cycle %0d: got out=%h grant=%b valid=%b cc=%h, want out=ff grant=0000 valid=0 cc=0000",
                 c, if_rr.out, if_rr.grant, if_rr.valid, if_rr.conflict_count);
      end
    end
    reset = 1'b0;
    tick();
    tests_run++;
    if ({if_fp.out, if_fp.grant, if_fp.valid, if_fp.conflict, if_fp.conflict_count} !== {8'h44, 4'b1000, 1'b1, 1'b1, 16'h0001}) begin
      tests_failed++;
      $display("FAIL reset_release_fp: got out=%h grant=%b valid=%b conflict=%b cc=%h, want out=44 grant=1000 valid=1 conflict=1 cc=0001",
               if_fp.out, if_fp.grant, if_fp.valid, if_fp.conflict, if_fp.conflict_count);
    end
    tests_run++;
    if ({if_rr.out, if_rr.grant} !== {8'h11, 4'b0001}) begin
      tests_failed++;
      $display("FAIL reset_release_rr: got out=%h grant=%b, want out=11 grant=0001", if_rr.out, if_rr.grant);
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    drive(32'h44332211, 4'b0101, 1'b0);
    tick();
    tests_run++;
    if ({if_fp.out, if_fp.grant, if_fp.valid, if_fp.conflict, if_fp.conflict_count} !== {8'h33, 4'b0100, 1'b1, 1'b1, 16'h0001}) begin
      tests_failed++;
      $display("FAIL fp_0101: got out=%h grant=%b valid=%b conflict=%b cc=%h, want out=33 grant=0100 valid=1 conflict=1 cc=0001",
               if_fp.out, if_fp.grant, if_fp.valid, if_fp.conflict, if_fp.conflict_count);
    end
    drive(32'h44332211, 4'b0000, 1'b0);
    tick();
    tests_run++;
    if ({if_fp.out, if_fp.grant, if_fp.valid, if_fp.conflict, if_fp.conflict_count} !== {8'hFF, 4'b0000, 1'b0, 1'b0, 16'h0001}) begin
      tests_failed++;
      $display("FAIL fp_idle: got out=%h grant=%b valid=%b conflict=%b cc=%h, want out=ff grant=0000 valid=0 conflict=0 cc=0001",
               if_fp.out, if_fp.grant, if_fp.valid, if_fp.conflict, if_fp.conflict_count);
    end
    drive(32'h44332211, 4'b0011, 1'b0);
    tick();
    tests_run++;
    if ({if_fp.out, if_fp.grant, if_fp.valid, if_fp.conflict_count} !== {8'h22, 4'b0010, 1'b1, 16'h0002}) begin
      tests_failed++;
      $display("FAIL fp_0011: got out=%h grant=%b valid=%b cc=%h, want out=22 grant=0010 valid=1 cc=0002",
               if_fp.out, if_fp.grant, if_fp.valid, if_fp.conflict_count);
    end
    drive(32'h44332211, 4'b0001, 1'b0);
    tick();
    tests_run++;
    if ({if_fp.out, if_fp.grant, if_fp.conflict, if_fp.conflict_count} !== {8'h11, 4'b0001, 1'b0, 16'h0002}) begin
      tests_failed++;
      $display("FAIL fp_0001: got out=%h grant=%b conflict=%b cc=%h, want out=11 grant=0001 conflict=0 cc=0002",
               if_fp.out, if_fp.grant, if_fp.conflict, if_fp.conflict_count);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_grant [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [7:0] exp_out   [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22};
    do_reset();
    drive(32'h44332211, 4'b1111, 1'b0);
    for (int c = 0; c < 6; c++) begin
      tick();
      tests_run++;
      if ({if_rr.grant, if_rr.out, if_rr.valid} !== {exp_grant[c], exp_out[c], 1'b1}) begin
        tests_failed++;
        $display("FAIL rr_seq cycle %0d: got grant=%b out=%h valid=%b, want grant=%b out=%h valid=1",
                 c, if_rr.grant, if_rr.out, if_rr.valid, exp_grant[c], exp_out[c]);
      end
    end
    tests_run++;
    if (if_rr.conflict_count !== 16'd6) begin
      tests_failed++;
      $display("FAIL rr_conflict_count: got %0d, want 6", if_rr.conflict_count);
    end
    drive(32'h44332211, 4'b0000, 1'b0);
    tick();
    drive(32'h44332211, 4'b1001, 1'b0);
    tick();
    tests_run++;
    if (if_rr.grant !== 4'b1000) begin
      tests_failed++;
      $display("FAIL rr_idle_keeps_ptr: got grant=%b, want 1000", if_rr.grant);
    end
  endtask

  task automatic test_hold_lock();
    do_reset();
    drive(32'h44332211, 4'b0010, 1'b0);
    tick();
    drive(32'h44332211, 4'b1111, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if ({if_rr.grant, if_rr.out, if_rr.conflict} !== {4'b0010, 8'h22, 1'b1}) begin
        tests_failed++;
        $display("FAIL hold_lock cycle %0d: got grant=%b out=%h conflict=%b, want grant=0010 out=22 conflict=1",
                 c, if_rr.grant, if_rr.out, if_rr.conflict);
      end
    end
    drive(32'h44332211, 4'b1101, 1'b1);
    tick();
    tests_run++;
    if ({if_rr.grant, if_rr.conflict_count} !== {4'b0100, 16'd4}) begin
      tests_failed++;
      $display("FAIL hold_drop: got grant=%b cc=%0d, want grant=0100 cc=4", if_rr.grant, if_rr.conflict_count);
    end
    // Reset while locked, then release with hold still high: no lock survives.
    reset = 1'b1;
    drive(32'h44332211, 4'b1111, 1'b1);
    tick();
    tests_run++;
    if ({if_rr.grant, if_rr.valid} !== {4'b0000, 1'b0}) begin
      tests_failed++;
      $display("FAIL hold_reset: got grant=%b valid=%b, want grant=0000 valid=0", if_rr.grant, if_rr.valid);
    end
    reset = 1'b0;
    tick();
    tests_run++;
    if (if_rr.grant !== 4'b0001) begin
      tests_failed++;
      $display("FAIL hold_after_reset: got grant=%b, want 0001", if_rr.grant);
    end
    // Hold with nothing granted behaves like plain arbitration.
    do_reset();
    drive(32'h44332211, 4'b0100, 1'b1);
    tick();
    tests_run++;
    if ({if_fp.grant, if_rr.grant} !== {4'b0100, 4'b0100}) begin
      tests_failed++;
      $display("FAIL hold_no_grant: got fp=%b rr=%b, want fp=0100 rr=0100", if_fp.grant, if_rr.grant);
    end
  endtask

  task automatic test_data_follow();
    do_reset();
    drive(32'h443322A5, 4'b0001, 1'b0);
    tick();
    drive(32'h4433225A, 4'b0001, 1'b0);
    tests_run++;
    if (if_fp.out !== 8'hA5) begin
      tests_failed++;
      $display("FAIL data_first: got out=%h, want a5", if_fp.out);
    end
    tick();
    tests_run++;
    if (if_fp.out !== 8'h5A) begin
      tests_failed++;
      $display("FAIL data_second: got out=%h, want 5a", if_fp.out);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(32'h44332211, 4'b0011, 1'b0);
    repeat (65534) @(posedge clk);
    #1;
    tests_run++;
    if (if_fp.conflict_count !== 16'hFFFE) begin
      tests_failed++;
      $display("FAIL sat_fffe: got cc=%h, want fffe", if_fp.conflict_count);
    end
    tick();
    tests_run++;
    if (if_fp.conflict_count !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL sat_ffff: got cc=%h, want ffff", if_fp.conflict_count);
    end
    repeat (5) tick();
    tests_run++;
    if ({if_fp.conflict_count, if_rr.conflict_count} !== {16'hFFFF, 16'hFFFF}) begin
      tests_failed++;
      $display("FAIL sat_hold: got fp=%h rr=%h, want ffff ffff", if_fp.conflict_count, if_rr.conflict_count);
    end
    do_reset();
    #1;
    tests_run++;
    if ({if_fp.conflict_count, if_rr.conflict_count} !== {16'h0000, 16'h0000}) begin
      tests_failed++;
      $display("FAIL sat_reset: got fp=%h rr=%h, want 0000 0000", if_fp.conflict_count, if_rr.conflict_count);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(32'h44332211, 4'b0000, 1'b0);
    #2;
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_hold_lock();
    test_data_follow();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
